// File: rtl/wb_dma_copy.sv
// rtl/wb_dma_copy.sv - Wishbone classic block-copy initiator (read one word, write one word)
//
// Optional feature macro: WB_DMA_TIMEOUT_EN (watchdog abort after TIMEOUT_CYCLES
// strobe cycles without a termination). Without it the initiator waits forever.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i                  start pulse, sampled only while idle
//   src_i, dst_i, len_i      source/destination byte addresses, word count
//   busy_o, done_o, error_o  status: in progress, completion pulse, sticky error
//   count_o                  words fully written in the current/last transfer
//   cyc_o, stb_o, we_o       Wishbone initiator strobes
//   adr_o, sel_o, dat_o      word-aligned address, byte selects, write data
//   dat_i, ack_i, err_i, rty_i  read data and responder terminations

module wb_dma_copy #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] src_i,
    input  logic [31:0] dst_i,
    input  logic [15:0] len_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [15:0] count_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] adr_o,
    output logic [3:0]  sel_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        err_i,
    input  logic        rty_i
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_WRITE   = 3'd2,
        S_BACKOFF = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_src;
    logic [31:0] r_dst;
    logic [15:0] r_rem;
    logic [15:0] r_count;
    logic [31:0] r_buf;
    logic        r_error;
    logic        r_retry_we;   // access to reissue after BACKOFF is a write

    logic        w_access;     // a bus access is being presented this cycle
    logic        w_term;       // any termination seen this cycle
    logic        w_timeout;

    // The address low bits are discarded; keep them visible to lint as intentionally unused.
    logic [3:0]  w_unused_lsbs;
    assign w_unused_lsbs = {src_i[1:0], dst_i[1:0]};

    assign w_access = (r_state == S_READ) || (r_state == S_WRITE);
    assign w_term   = err_i || rty_i || ack_i;

`ifdef WB_DMA_TIMEOUT_EN
    localparam int WDW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [WDW-1:0] r_wdog;

    // Counts strobe cycles with no termination. Any termination (including the
    // ack that moves to the next access) and every non-access state clears it,
    // so each new access starts from zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wdog <= '0;
        end else if (w_access && !w_term) begin
            r_wdog <= r_wdog + 1'b1;
        end else begin
            r_wdog <= '0;
        end
    end

    // Fires on the last of TIMEOUT_CYCLES unanswered strobe cycles.
    assign w_timeout = w_access && !w_term && (r_wdog == WDW'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
    assign w_timeout        = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; termination priority is err > rty > ack.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_next = (len_i == 16'd0) ? S_FINISH : S_READ;
                end
            end
            S_READ, S_WRITE: begin
                if (err_i) begin
                    w_next = S_FINISH;
                end else if (rty_i) begin
                    w_next = S_BACKOFF;
                end else if (ack_i) begin
                    if (r_state == S_READ) begin
                        w_next = S_WRITE;
                    end else begin
                        w_next = (r_rem == 16'd1) ? S_FINISH : S_READ;
                    end
                end else if (w_timeout) begin
                    w_next = S_FINISH;
                end
            end
            S_BACKOFF: begin
                w_next = r_retry_we ? S_WRITE : S_READ;
            end
            S_FINISH: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: pointers, remaining/count, data buffer, sticky error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_src      <= '0;
            r_dst      <= '0;
            r_rem      <= '0;
            r_count    <= '0;
            r_buf      <= '0;
            r_error    <= 1'b0;
            r_retry_we <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_src   <= {src_i[31:2], 2'b00};
                        r_dst   <= {dst_i[31:2], 2'b00};
                        r_rem   <= len_i;
                        r_count <= '0;
                        r_error <= 1'b0;
                    end
                end
                S_READ, S_WRITE: begin
                    if (err_i) begin
                        r_error <= 1'b1;
                    end else if (rty_i) begin
                        r_retry_we <= (r_state == S_WRITE);
                    end else if (ack_i) begin
                        if (r_state == S_READ) begin
                            r_buf <= dat_i;
                        end else begin
                            // Pointers wrap naturally modulo 2^32.
                            r_src   <= r_src + 32'd4;
                            r_dst   <= r_dst + 32'd4;
                            r_count <= r_count + 16'd1;
                            r_rem   <= r_rem - 16'd1;
                        end
                    end else if (w_timeout) begin
                        r_error <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Bus outputs decode straight from the state register, so an asynchronous
    // reset drops cyc/stb/busy immediately and strobes fall the cycle after
    // the final termination.
    always_comb begin
        cyc_o = w_access;
        stb_o = w_access;
        we_o  = (r_state == S_WRITE);
        sel_o = w_access ? 4'hF : 4'h0;
        dat_o = (r_state == S_WRITE) ? r_buf : 32'd0;
        case (r_state)
            S_READ:    adr_o = r_src;
            S_WRITE:   adr_o = r_dst;
            S_BACKOFF: adr_o = r_retry_we ? r_dst : r_src;
            default:   adr_o = 32'd0;
        endcase
    end

    assign busy_o  = (r_state != S_IDLE);
    assign done_o  = (r_state == S_FINISH);
    assign error_o = r_error;
    assign count_o = r_count;

endmodule
